// File: rtl/spi_sram_pkg.sv
// Shared constants, FSM state encoding and helpers for the serial SRAM master.
package spi_sram_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] CMD_MODE  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_INIT_GAP  = 3'd0,
    S_INIT_MODE = 3'd1,
    S_IDLE      = 3'd2,
    S_CMD       = 3'd3,
    S_ADDR      = 3'd4,
    S_DATA      = 3'd5,
    S_STOP      = 3'd6
  } state_e;

  // Address bytes go out most significant first: index 0 = [23:16].
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] addr,
                                           input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[23:16];
      2'd1:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SCK divider plus one-byte MSB-first SPI mode-0 shifter.
// mosi is preloaded on start and advanced on falling edges; miso is
// captured on every falling edge into a running shift register so a byte
// may straddle two frames (early_i selects the 7th fall as byte-complete).
module spi_byte_shifter #(
  parameter int SPI_DIV = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       early_i,
  input  logic       miso_i,
  output logic       tick_o,
  output logic       active_o,
  output logic       done_o,
  output logic       rx_strobe_o,
  output logic [7:0] rx_byte_o,
  output logic       sck_o,
  output logic       mosi_o
);

  localparam logic [7:0] DIV_LAST = 8'(SPI_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       tick_s, rise_s, fall_s;

  assign tick_s = (div_q == DIV_LAST);
  assign rise_s = active_q & tick_s & ~sck_q;
  assign fall_s = active_q & tick_s & sck_q;

  assign tick_o      = tick_s;
  assign active_o    = active_q;
  assign done_o      = done_q;
  assign rx_strobe_o = fall_s & (bit_q == (early_i ? 3'd6 : 3'd7));
  assign rx_byte_o   = {rx_q, miso_i};
  assign sck_o       = sck_q;
  assign mosi_o      = mosi_q;

  // Next-state: divider wrap, byte load, sck toggling and bit shifting.
  always_comb begin
    div_d    = tick_s ? 8'd0 : div_q + 8'd1;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      mosi_d   = tx_byte_i[7];
      tx_d     = {tx_byte_i[6:0], 1'b0};
      bit_d    = 3'd0;
    end else if (rise_s) begin
      sck_d = 1'b1;
    end else if (fall_s) begin
      sck_d = 1'b0;
      rx_d  = {rx_q[5:0], miso_i};
      if (bit_q == 3'd7) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        bit_d    = 3'd0;
      end else begin
        bit_d  = bit_q + 3'd1;
        mosi_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end else begin
      sck_d = sck_q;
    end
  end

  // Shifter state registers; reset parks sck and mosi low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q    <= 8'd0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      tx_q     <= 8'd0;
      rx_q     <= 7'd0;
      bit_q    <= 3'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: rtl/spi_sram_master.sv
// SPI initiator for a 23LC1024-style serial SRAM: init MODE write, then
// byte-burst READ/WRITE frames driven from a request/valid-ready interface.
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int         SPI_DIV   = 2,
  parameter logic [7:0] MODE_BYTE = 8'h40,
  parameter int         LEN_BITS  = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [23:0]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic [7:0]          wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                ssn,
  output logic                sck,
  output logic                mosi,
  input  logic                miso
);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic                  gap_q, gap_d;
  logic                  ssn_q, ssn_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [7:0]            rd_data_q, rd_data_d;

  logic                  sh_start_s, sh_early_s;
  logic [7:0]            sh_tx_s;
  logic                  tick_s, active_s, done_s, rx_strobe_s;
  logic [7:0]            rx_byte_s;

  spi_byte_shifter #(.SPI_DIV(SPI_DIV)) u_shifter (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (sh_start_s),
    .tx_byte_i  (sh_tx_s),
    .early_i    (sh_early_s),
    .miso_i     (miso),
    .tick_o     (tick_s),
    .active_o   (active_s),
    .done_o     (done_s),
    .rx_strobe_o(rx_strobe_s),
    .rx_byte_o  (rx_byte_s),
    .sck_o      (sck),
    .mosi_o     (mosi)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign ssn       = ssn_q;

  // Frame sequencer: picks the next byte to shift and controls ssn/handshakes.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    ssn_d       = ssn_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    wr_ready_d  = 1'b0;
    sh_start_s  = 1'b0;
    sh_tx_s     = 8'h00;
    // Read data lags the byte framing by one bit: the responder launches
    // bit 7 on the last address rise, so each read byte completes early.
    sh_early_s  = (state_q == S_DATA) && !write_q;
    rd_valid_d  = rx_strobe_s && (state_q == S_DATA) && !write_q;
    rd_data_d   = rd_valid_d ? rx_byte_s : rd_data_q;
    case (state_q)
      S_INIT_GAP: begin
        if (tick_s) begin
          if (gap_q) begin
            gap_d      = 1'b0;
            ssn_d      = 1'b0;
            idx_d      = 2'd0;
            sh_start_s = 1'b1;
            sh_tx_s    = CMD_MODE;
            state_d    = S_INIT_MODE;
          end else begin
            gap_d = 1'b1;
          end
        end else begin
          gap_d = gap_q;
        end
      end
      S_INIT_MODE: begin
        if (done_s) begin
          if (idx_q == 2'd0) begin
            idx_d      = 2'd1;
            sh_start_s = 1'b1;
            sh_tx_s    = MODE_BYTE;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          cnt_d       = req_len;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          ssn_d       = 1'b0;
          sh_start_s  = 1'b1;
          sh_tx_s     = req_write ? CMD_WRITE : CMD_READ;
          state_d     = S_CMD;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_CMD: begin
        if (done_s) begin
          idx_d      = 2'd0;
          sh_start_s = 1'b1;
          sh_tx_s    = addr_byte(addr_q, 2'd0);
          state_d    = S_ADDR;
        end else begin
          idx_d = idx_q;
        end
      end
      S_ADDR: begin
        if (done_s) begin
          if (idx_q == 2'd2) begin
            state_d = S_DATA;
          end else begin
            idx_d      = idx_q + 2'd1;
            sh_start_s = 1'b1;
            sh_tx_s    = addr_byte(addr_q, idx_q + 2'd1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DATA: begin
        if (done_s) begin
          if (cnt_q == {LEN_BITS{1'b0}}) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q - {{(LEN_BITS-1){1'b0}}, 1'b1};
          end
        end else if (!active_s) begin
          if (write_q) begin
            // Underrun simply stalls here with sck low and ssn asserted.
            if (wr_valid) begin
              wr_ready_d = 1'b1;
              sh_start_s = 1'b1;
              sh_tx_s    = wr_data;
            end else begin
              wr_ready_d = 1'b0;
            end
          end else begin
            sh_start_s = 1'b1;
            sh_tx_s    = 8'h00;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          if (!ssn_q) begin
            ssn_d = 1'b1;
          end else if (gap_q) begin
            gap_d       = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end else begin
            gap_d = 1'b1;
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d     = S_INIT_GAP;
        ssn_d       = 1'b1;
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        gap_d       = 1'b0;
      end
    endcase
  end

  // Control registers; reset aborts any frame and restarts initialisation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_INIT_GAP;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      cnt_q       <= {LEN_BITS{1'b0}};
      idx_q       <= 2'd0;
      gap_q       <= 1'b0;
      ssn_q       <= 1'b1;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      ssn_q       <= ssn_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// Directed bench for spi_sram_master with a small behavioural serial SRAM.
module tb_spi_sram_master;

  localparam int SPI_DIV = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, ssn, sck, mosi;
  logic        miso = 1'b0;

  spi_sram_master #(.SPI_DIV(SPI_DIV), .MODE_BYTE(8'h40), .LEN_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .ssn(ssn),
    .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model state
  logic [7:0]  mem [0:131071];
  int          m_cnt = 0;
  logic [31:0] m_sr = 32'd0;
  logic [7:0]  m_cmd = 8'd0;
  logic [7:0]  m_mode = 8'd0;
  int          m_addr = 0;
  logic [7:0]  m_bytes[$];
  logic [7:0]  f_bytes[$];
  int          f_pulses = 0;
  int          n_frames = 0;
  int          n_rises = 0;

  // Observers
  logic [7:0]  rd_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rexp_q[$];
  logic [7:0]  wd [0:3];
  int          wr_cnt = 0;
  int          hi_cnt = 0;
  int          acc_cnt = 0;
  int          acc_hi = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: shift mosi on rises, launch read bits from the 32nd rise on.
  always @(negedge ssn) begin
    m_cnt = 0;
    m_bytes.delete();
  end

  always @(posedge sck) begin
    n_rises++;
    if (ssn === 1'b0) begin
      m_cnt++;
      m_sr = {m_sr[30:0], mosi};
      if (m_cnt % 8 == 0) m_bytes.push_back(m_sr[7:0]);
      if (m_cnt == 8) m_cmd = m_sr[7:0];
      if (m_cmd == 8'h01 && m_cnt == 16) m_mode = m_sr[7:0];
      if (m_cnt == 32) m_addr = int'(m_sr[16:0]);
      if (m_cmd == 8'h03 && m_cnt >= 32)
        miso = mem[(m_addr + (m_cnt - 32) / 8) % 131072][7 - ((m_cnt - 32) % 8)];
      if (m_cmd == 8'h02 && m_cnt > 32 && (m_cnt - 32) % 8 == 0)
        mem[(m_addr + (m_cnt - 32) / 8 - 1) % 131072] = m_sr[7:0];
    end
  end

  always @(posedge ssn) begin
    if (m_cnt != 0) begin
      f_bytes  = m_bytes;
      f_pulses = m_cnt;
      n_frames++;
    end
  end

  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back(rd_data);
    if (wr_ready) wr_cnt++;
    if (ssn) hi_cnt++;
    else hi_cnt = 0;
    if (req_valid && req_ready) begin
      acc_cnt++;
      acc_hi = hi_cnt;
    end
  end

  task automatic wait_frames(input int n);
    int t = 0;
    while (n_frames < n && t < 5000) begin @(negedge clk); t++; end
    check_eq("frame_wait", 32'(n_frames >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(req_ready && ssn) && t < 5000) begin @(negedge clk); t++; end
    check_eq("idle_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int pulses);
    check_eq({tag, "_pulses"}, pulses == f_pulses ? 32'(pulses) : 32'(f_pulses), 32'(pulses));
    check_eq({tag, "_nbytes"}, 32'(f_bytes.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_eq(tag, (i < f_bytes.size()) ? {24'h0, f_bytes[i]} : 32'hDEAD_BEEF, {24'h0, exp_q[i]});
  endtask

  task automatic check_rd(input string tag);
    check_eq({tag, "_count"}, 32'(rd_q.size()), 32'(rexp_q.size()));
    for (int i = 0; i < rexp_q.size(); i++)
      check_eq(tag, (i < rd_q.size()) ? {24'h0, rd_q[i]} : 32'hDEAD_BEEF, {24'h0, rexp_q[i]});
  endtask

  task automatic issue(input logic w, input logic [23:0] a, input logic [7:0] l);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    while (!req_ready && t < 5000) begin @(negedge clk); t++; end
    check_eq("req_accept_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("req_ready_drop", 32'(req_ready), 32'd0);
  endtask

  task automatic run_write(input logic [23:0] a, input logic [7:0] l, input int stall_idx);
    int t;
    int r0;
    issue(1'b1, a, l);
    for (int k = 0; k <= int'(l); k++) begin
      if (k == stall_idx) begin
        t = 0;
        while (!(m_cnt == 32 + 8 * k && sck == 1'b0) && t < 5000) begin @(negedge clk); t++; end
        check_eq("stall_reach", 32'(t < 5000), 32'd1);
        r0 = n_rises;
        repeat (20) @(negedge clk);
        check_eq("stall_sck_rises", 32'(n_rises - r0), 32'd0);
        check_eq("stall_ssn_low", 32'(ssn), 32'd0);
        check_eq("stall_sck_low", 32'(sck), 32'd0);
      end
      wr_data  = wd[k];
      wr_valid = 1'b1;
      @(negedge clk);
      t = 1;
      while (!wr_ready && t < 5000) begin @(negedge clk); t++; end
      check_eq("wr_ready_wait", 32'(wr_ready), 32'd1);
      wr_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int base;
    int a0;
    for (int i = 0; i < 131072; i++) mem[i] = i[7:0];
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 24'h0;
    req_len = 8'h0; wr_data = 8'h0; wr_valid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_ssn", 32'(ssn), 32'd1);
    check_eq("rst_sck", 32'(sck), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_strobes", {30'd0, wr_ready, rd_valid}, 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);

    // Init: ssn high for 2 ticks (4 clk), then 01,40 over 16 pulses
    rstn = 1'b1;
    t = 0;
    while (ssn && t < 100) begin @(negedge clk); t++; end
    check_eq("init_gap_cycles", 32'(t), 32'd4);
    wait_frames(1);
    wait_idle();
    exp_q = '{8'h01, 8'h40};
    check_frame("init_frame", 16);
    check_eq("init_mode_byte", 32'(m_mode), 32'h40);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Write 3 bytes at 0x000123, no underrun
    base = n_frames; a0 = wr_cnt;
    wd[0] = 8'hAA; wd[1] = 8'h55; wd[2] = 8'hC3;
    run_write(24'h000123, 8'd2, -1);
    wait_frames(base + 1);
    wait_idle();
    exp_q = '{8'h02, 8'h00, 8'h01, 8'h23, 8'hAA, 8'h55, 8'hC3};
    check_frame("wr_frame", 56);
    check_eq("wr_ready_pulses", 32'(wr_cnt - a0), 32'd3);
    check_eq("mem_123", 32'(mem[17'h123]), 32'hAA);
    check_eq("mem_124", 32'(mem[17'h124]), 32'h55);
    check_eq("mem_125", 32'(mem[17'h125]), 32'hC3);

    // Read it back
    rd_q.delete(); base = n_frames;
    issue(1'b0, 24'h000123, 8'd2);
    wait_frames(base + 1);
    wait_idle();
    rexp_q = '{8'hAA, 8'h55, 8'hC3};
    check_rd("rd_123");
    exp_q = '{8'h03, 8'h00, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00};
    check_frame("rd_frame", 56);

    // Read across a byte boundary of the address pattern
    rd_q.delete(); base = n_frames;
    issue(1'b0, 24'h0000FE, 8'd2);
    wait_frames(base + 1);
    wait_idle();
    rexp_q = '{8'hFE, 8'hFF, 8'h00};
    check_rd("rd_0fe");

    // Write with a 20-cycle underrun before the second data byte
    base = n_frames;
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    run_write(24'h000200, 8'd2, 1);
    wait_frames(base + 1);
    wait_idle();
    exp_q = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    check_frame("stall_frame", 56);
    check_eq("mem_201", 32'(mem[17'h201]), 32'h22);
    check_eq("mem_202", 32'(mem[17'h202]), 32'h33);

    // Back-to-back single-byte reads with req_valid held high
    rd_q.delete(); base = n_frames; a0 = acc_cnt;
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000010; req_len = 8'd0;
    t = 0;
    while (acc_cnt == a0 && t < 5000) begin @(posedge clk); #2; t++; end
    req_addr = 24'h000020;
    t = 0;
    while (acc_cnt == a0 + 1 && t < 5000) begin @(posedge clk); #2; t++; end
    req_valid = 1'b0;
    check_eq("b2b_ssn_gap_ok", 32'(acc_hi >= 2 * SPI_DIV), 32'd1);
    wait_frames(base + 2);
    wait_idle();
    repeat (20) @(negedge clk);
    check_eq("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    check_eq("b2b_frames", 32'(n_frames - base), 32'd2);
    rexp_q = '{8'h10, 8'h20};
    check_rd("b2b_rd");

    // Asynchronous reset in the middle of the address phase
    base = n_frames;
    issue(1'b1, 24'h000345, 8'd0);
    t = 0;
    while (!(m_cnt >= 20 && sck == 1'b1) && t < 5000) begin @(negedge clk); t++; end
    check_eq("mid_addr_reach", 32'(sck), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_eq("abort_ssn", 32'(ssn), 32'd1);
    check_eq("abort_sck", 32'(sck), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_frames(base + 2);
    wait_idle();
    exp_q = '{8'h01, 8'h40};
    check_frame("reinit_frame", 16);
    check_eq("mem_345_untouched", 32'(mem[17'h345]), 32'h45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sram_master.md
Name: spi_sram_master

Overview:
- SPI initiator for the external 128 KB serial SRAM (23LC1024-style command set) on the soc ssn/sck/mosi/miso pins.
- Accepts byte-burst read/write requests from the CPU/bus side.
- Issues the MODE, READ and WRITE command sequences.
- Streams data bytes through valid/ready handshakes.
- It is the initiator end of the interface that the team's spi_ram bench model responds to.

Parameters:
- SPI_DIV, 2: clk cycles per SCK half-period; legal range 1..255.
- MODE_BYTE, 8'h40: value sent after CMD_MODE at init (sequential mode).
- LEN_BITS, 8: width of the burst length field.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  24  start byte address.
- req_len  in  LEN_BITS  byte count minus 1. 0 means 1 byte; 255 means 256 bytes.
- wr_data  in  8  write byte.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  1-cycle pulse; the block has taken wr_data.
- rd_data  out  8  read byte.
- rd_valid  out  1  1-cycle pulse; rd_data is valid. There is no backpressure.
- busy  out  1  initialisation or transfer in progress.
- ssn  out  1  chip select, active low.
- sck  out  1  SPI clock, mode 0 (idles low).
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in, MSB first.

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer):
  - ssn=1, sck=0, mosi=0.
  - req_ready=0, busy=1, wr_ready=0, rd_valid=0, rd_data=0.
  - State=INIT_GAP. All counters are 0.
- SCK generation:
  - A divider counts 0..SPI_DIV-1; each wrap is one half-period "tick".
  - sck toggles on ticks only while a frame is shifting.
  - mosi changes only when sck falls, or is preloaded before the first rise. It is stable for each rising edge.
- MISO timing (matches the model):
  - The responder launches data bit 7 on the 32nd rising edge, i.e. the last address bit.
  - It launches each later bit on the next rising edge.
  - The master samples miso on sck falling edges.
- States:
  - INIT_GAP: ssn high for 2 ticks -> INIT_MODE.
  - INIT_MODE: ssn low; shift 8'h01 then MODE_BYTE (16 sck pulses) -> STOP.
  - IDLE: req_ready=1, busy=0. On req_valid, latch req_write, req_addr and req_len; req_ready drops the next cycle -> CMD.
  - CMD: shift 8'h02 (write) or 8'h03 (read) -> ADDR.
  - ADDR: shift req_addr[23:16], [15:8], [7:0] -> DATA.
  - DATA: handles len+1 bytes; write and read rules are below. After the last byte -> STOP.
  - STOP: after the last falling edge, sck=0; ssn=1 on the next tick; hold ssn high for 2 ticks -> IDLE. The same holds after INIT_MODE.
- Write path in DATA:
  - Before each byte, wait for wr_valid.
  - On acceptance, pulse wr_ready for one cycle and load the shifter.
  - If wr_valid is low (underrun), sck holds low and ssn stays low until data arrives. There is no timeout.
  - Total sck pulses for N bytes = 32 + 8N.
- Read path in DATA:
  - Bits are captured on falling edges 32 .. 32+8N-1, counting from 1 at the CMD bit-7 falling edge.
  - rd_valid pulses one clk after each 8th capture, with rd_data = assembled byte.
  - Total sck pulses for N bytes = 32 + 8N. The final pulse is a harmless trailing pulse.
  - mosi is held 0 during read data.
- Counters and widths:
  - Byte counter is LEN_BITS wide and counts down. It is compared to 0 for the last byte; there is no wrap.
  - Bit counter is 3 bits.
  - Address wrap is the device's concern; the master never increments the address.
- Simultaneous events: req_valid during INIT or a transfer is ignored until req_ready=1. A request is accepted only in a cycle with req_valid && req_ready.
- Reset mid-frame: the frame is aborted and ssn deasserted asynchronously. After release, the full INIT sequence repeats.

Decomposition:
- Package spi_sram_pkg:
  - CMD_MODE=8'h01, CMD_WRITE=8'h02, CMD_READ=8'h03.
  - State enum localparams.
  - ADDR_W=24.
- Sub-module spi_byte_shifter:
  - Contains the divider, sck toggling, and 8-bit MSB-first shift register (mosi out, miso falling-edge capture).
  - Has a start/done handshake and a one-sample-early capture offset input.
- Top FSM sequences the bytes.

Test Plan:
- Reset release, SPI_DIV=2 -> ssn high 2 ticks, then ssn low with mosi bytes 01,40 over 16 pulses, then ssn high; busy=0, req_ready=1 afterwards.
- Write addr 0x000123 len 2 with data AA,55,C3 always valid -> mosi stream 02 00 01 23 AA 55 C3; 3 wr_ready pulses; spi_ram sram[0x123..0x125]=AA,55,C3.
- Read addr 0x000123 len 2 after the previous write -> rd_valid ×3 with rd_data AA,55,C3; then read addr 0x0000FE len 2 on a fresh model -> FE,FF,00.
- Write with wr_valid held low 20 cycles before byte 2 -> sck stays low and ssn low for the stall; byte completes correctly after wr_valid rises.
- Assert rstn low mid-ADDR -> ssn=1 and sck=0 in the same cycle; after release, INIT bytes 01,40 reappear and the model returns to S_IDLE.
- Back-to-back requests with req_valid held -> second accepted only after ssn has been high ≥2 ticks; no request is lost or duplicated.
